dmem_mmio_responder: RTL and testbench

// Responder side of the core's data-memory port. Serves M-stage loads and stores from the pipelined

---
 rtl/riscv_mmio_pkg.sv | 18 +
 rtl/sync_fifo.sv | 38 +++
 rtl/dmem_mmio_responder.sv | 52 +++++
 tb/tb_dmem_mmio_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_pkg.sv
// riscv_mmio_pkg: MMIO address map, region type and address decode for the data-memory responder
package riscv_mmio_pkg;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] MMIO_CYCLE  = MMIO_BASE;
  localparam logic [31:0] MMIO_STATUS = MMIO_BASE + 32'h4;
  localparam logic [31:0] MMIO_TXDATA = MMIO_BASE + 32'h8;
  localparam logic [31:0] MMIO_DROPS  = MMIO_BASE + 32'hC;
  typedef enum logic [2:0] {REG_RAM, REG_CYCLE, REG_STATUS, REG_TX, REG_DROPS, REG_NONE} region_t;
  function automatic region_t decode(input logic [31:0] a, input logic [31:0] ram_bytes);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return w < ram_bytes    ? REG_RAM    :
           w == MMIO_CYCLE  ? REG_CYCLE  :
           w == MMIO_STATUS ? REG_STATUS :
           w == MMIO_TXDATA ? REG_TX     :
           w == MMIO_DROPS  ? REG_DROPS  : REG_NONE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with explicit count; a push while full is accepted when a pop frees a slot
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_pop, do_push;
  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= push_data;
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: single-cycle data RAM plus MMIO window (cycle counter, TX FIFO, drop counter)
module dmem_mmio_responder
  import riscv_mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_write,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_write_data,
  output logic [31:0] dmem_read_data,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);
  localparam int IW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] cycle_cnt, drops;
  logic [CW-1:0] count;
  logic full, empty, push, pop, drop;
  region_t region;
  assign region   = decode(dmem_addr, 32'(RAM_WORDS * 4));
  assign push     = dmem_write & (region == REG_TX);
  assign pop      = tx_valid & tx_ready;
  assign drop     = push & full & !pop;
  assign tx_valid = !empty;
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .push_data(dmem_write_data), .pop(pop),
    .head(tx_data), .count(count), .full(full), .empty(empty)
  );
  // RAM is deliberately outside the reset domain so contents survive a core reset
  always_ff @(posedge clk)
    if (dmem_write && region == REG_RAM && !reset) ram[dmem_addr[IW+1:2]] <= dmem_write_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      drops     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (dmem_write && region == REG_DROPS) drops <= '0;
      else if (drop && drops != '1) drops <= drops + 32'd1;
    end
  end
  always_comb
    dmem_read_data = region == REG_RAM    ? ram[dmem_addr[IW+1:2]] :
                     region == REG_CYCLE  ? cycle_cnt :
                     region == REG_STATUS ? {16'h0, 8'(count), 6'h0, empty, full} :
                     region == REG_DROPS  ? drops : 32'h0;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed scoreboard bench for the data-memory / MMIO responder
module tb_dmem_mmio_responder;
  logic clk = 1'b0, reset = 1'b1, dmem_write = 1'b0, tx_ready = 1'b0;
  logic [31:0] dmem_addr = '0, dmem_write_data = '0, dmem_read_data, tx_data;
  logic tx_valid;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] txq [$];
  logic [31:0] cyc_m = '0, drops_m = '0;

  localparam logic [31:0] A_CYC = 32'hFFFF_FF00, A_ST = 32'hFFFF_FF04, A_TX = 32'hFFFF_FF08, A_DR = 32'hFFFF_FF0C;

  dmem_mmio_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_write_data(dmem_write_data), .dmem_read_data(dmem_read_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] st(int n);
    return {16'h0, 8'(n), 6'h0, n == 0, n == 4};
  endfunction

  task automatic check(string tag, logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Advance one clock, updating the reference model with what the DUT sampled at the edge.
  task automatic tick();
    logic is_push, popd;
    is_push = dmem_write && {dmem_addr[31:2], 2'b00} == A_TX;
    popd = txq.size() > 0 && tx_ready;
    if (reset) begin
      txq.delete();
      drops_m = '0;
      cyc_m = '0;
    end else begin
      cyc_m++;
      if (popd) void'(txq.pop_front());
      if (is_push) begin
        if (txq.size() < 4) txq.push_back(dmem_write_data);
        else if (drops_m != '1) drops_m++;
      end
      if (dmem_write && {dmem_addr[31:2], 2'b00} == A_DR) drops_m = '0;
    end
    @(negedge clk);
  endtask

  task automatic rd(string tag, logic [31:0] a, logic [31:0] e);
    dmem_write = 1'b0;
    dmem_addr = a;
    exp_q.push_back(e);
    #1;
    check(tag, dmem_read_data);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    dmem_write = 1'b1;
    dmem_addr = a;
    dmem_write_data = d;
    tick();
    dmem_write = 1'b0;
  endtask

  task automatic chk_tx(string tag);
    #1;
    exp_q.push_back({31'h0, txq.size() > 0});
    check({tag, "_valid"}, {31'h0, tx_valid});
    if (txq.size() > 0) begin
      exp_q.push_back(txq[0]);
      check({tag, "_data"}, tx_data);
    end
  endtask

  initial begin
    @(negedge clk);
    tick();
    tick();
    chk_tx("rst_tx");
    rd("rst_status", A_ST, 32'h0000_0002);
    rd("rst_drops", A_DR, 32'h0);
    rd("rst_cycle", A_CYC, 32'h0);
    reset = 1'b0;
    // RAM store then same-cycle combinational read
    wr(32'h14, 32'hA5A5_5A5A);
    wr(32'h10, 32'h1234_5678);
    rd("ram_10", 32'h10, 32'h1234_5678);
    rd("ram_14", 32'h14, 32'hA5A5_5A5A);
    rd("ram_alias", 32'h13, 32'h1234_5678);
    // cycle counter from reset, then wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    rd("cycle_5", A_CYC, 32'd5);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1 release dut.cycle_cnt;
    cyc_m = 32'hFFFF_FFFF;
    rd("cycle_max", A_CYC, 32'hFFFF_FFFF);
    tick();
    rd("cycle_wrap", A_CYC, 32'h0);
    // fill FIFO, overflow, drain
    wr(A_TX, 32'hA); wr(A_TX, 32'hB); wr(A_TX, 32'hC); wr(A_TX, 32'hD);
    rd("status_full", A_ST, 32'h0000_0401);
    rd("txdata_rd", A_TX, 32'h0);
    wr(A_TX, 32'hE);
    rd("drops_1", A_DR, 32'h1);
    chk_tx("stall_head");
    tick();
    chk_tx("stall_hold");
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_tx("drain");
      tick();
    end
    chk_tx("drained");
    rd("status_empty", A_ST, 32'h0000_0002);
    // full with simultaneous pop and push
    tx_ready = 1'b0;
    wr(A_TX, 32'h100); wr(A_TX, 32'h101); wr(A_TX, 32'h102); wr(A_TX, 32'h103);
    tx_ready = 1'b1;
    wr(A_TX, 32'h104);
    rd("drops_same", A_DR, drops_m);
    rd("status_pp", A_ST, 32'h0000_0401);
    for (int i = 0; i < 4; i++) begin
      chk_tx("pp_drain");
      tick();
    end
    chk_tx("pp_drained");
    // single-entry push and pop in one cycle
    tx_ready = 1'b0;
    wr(A_TX, 32'h200);
    tx_ready = 1'b1;
    wr(A_TX, 32'h201);
    rd("status_one", A_ST, st(1));
    chk_tx("one_adv");
    tick();
    tx_ready = 1'b0;
    // DROPS clear, CYCLE write ignored, unmapped reads
    for (int i = 0; i < 6; i++) wr(A_TX, 32'h300 + 32'(i));
    rd("drops_3", A_DR, 32'd3);
    wr(A_DR, 32'h0);
    rd("drops_clr", A_DR, 32'h0);
    wr(A_CYC, 32'h0);
    rd("cycle_ro", A_CYC, cyc_m);
    rd("unmapped", 32'h8000_0000, 32'h0);
    rd("above_ram", 32'h100, 32'h0);
    // leave two words queued, one drop pending, then reset
    tx_ready = 1'b1;
    tick();
    tick();
    tx_ready = 1'b0;
    wr(A_TX, 32'h400); wr(A_TX, 32'h401);
    wr(A_TX, 32'h402);
    rd("drops_pre", A_DR, 32'd1);
    tick(); tick();
    tx_ready = 1'b1;
    tick(); tick();
    tx_ready = 1'b0;
    rd("status_two", A_ST, st(2));
    wr(32'h0, 32'h0000_CAFE);
    reset = 1'b1;
    dmem_write = 1'b1;
    dmem_addr = A_TX;
    dmem_write_data = 32'hDEAD;
    tick();
    dmem_write = 1'b0;
    chk_tx("rst2_tx");
    rd("rst2_status", A_ST, 32'h0000_0002);
    rd("rst2_drops", A_DR, 32'h0);
    rd("rst2_cycle", A_CYC, 32'h0);
    rd("rst2_ram0", 32'h0, 32'h0000_CAFE);
    reset = 1'b0;
    tick();
    rd("post_cycle", A_CYC, 32'd1);
    chk_tx("post_tx");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
